// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and pointer-code helpers for the asynchronous FIFO controllers.
// The write-side controller imports the same definitions.
package fifo_rd_ctrl_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int PTR_W      = ADDR_W + 1;
    localparam int FIFO_DEPTH = 2 ** ADDR_W;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_W-1] = gray[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Output stream of the FIFO read controller.
// Handshake: a word transfers on a clock edge where m_valid and m_ready are both 1;
// once m_valid is raised, m_valid and m_data hold until that transfer happens.
interface fifo_rd_ctrl_if;
    import fifo_rd_ctrl_pkg::*;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: fetches from the registered-read RAM
// into a 2-entry skid buffer and presents the words as a first-word-fall-through stream.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
(
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [PTR_W-1:0]  wr_ptr_gray,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    fifo_rd_ctrl_if.master    m,
    output logic [PTR_W-1:0]  rd_ptr_gray,
    output logic              empty,
    output logic [PTR_W-1:0]  rd_level
);

    ptr_t              wq2;
    ptr_t              wq2_bin;
    ptr_t              rd_ptr_bin_q, rd_ptr_bin_d;
    ptr_t              rd_ptr_gray_q, rd_ptr_gray_d;
    logic              empty_q, empty_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              pop;
    logic              fetch;
    logic [2:0]        committed;

    sync_2ff #(.WIDTH(PTR_W)) u_wptr_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d_i (wr_ptr_gray),
        .q_o (wq2)
    );

    assign wq2_bin = gray2bin(wq2);
    assign pop     = (occ_q != 2'd0) && m.m_ready;

    // Slots already claimed after this cycle's pop; a fetch is allowed only if one stays free.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch     = !empty_q && (committed < 3'd2);

    always_comb begin
        rd_ptr_bin_d  = rd_ptr_bin_q + {{(PTR_W-1){1'b0}}, fetch};
        rd_ptr_gray_d = bin2gray(rd_ptr_bin_d);
        empty_d       = (rd_ptr_gray_d == wq2);
        inflight_d    = fetch;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = ram_rd_data;
                end else begin
                    tail_d = ram_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = ram_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            empty_q       <= 1'b1;
            inflight_q    <= 1'b0;
            occ_q         <= 2'd0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            empty_q       <= empty_d;
            inflight_q    <= inflight_d;
            occ_q         <= occ_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    assign ram_rd_en   = fetch;
    assign ram_rd_addr = rd_ptr_bin_q[ADDR_W-1:0];
    assign rd_ptr_gray = rd_ptr_gray_q;
    assign empty       = empty_q;
    assign rd_level    = wq2_bin - rd_ptr_bin_q;
    assign m.m_data    = head_q;
    assign m.m_valid   = (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a behavioural write side and RAM feed words; a monitor checks
// every delivered word and every RAM address against queues filled when words are written.
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic [4:0] wr_ptr_gray;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic [4:0] rd_level;

  fifo_rd_ctrl_if s_if ();

  fifo_rd_ctrl dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .wr_ptr_gray (wr_ptr_gray),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m           (s_if.master),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_level    (rd_level)
  );

  // clock / reset
  always #5 rd_clk = ~rd_clk;

  // RAM model: 16x8, registered read port
  logic [7:0] mem [16];
  always @(posedge rd_clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // scoreboard state
  int         tests;
  int         fails;
  logic [7:0] exp_q [$];
  logic [3:0] addr_q [$];
  int         written;
  int         popped;
  int         fetch_cnt;
  logic [4:0] wbin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  logic       prev_stall;
  logic [7:0] prev_data;
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", s_if.m_valid, 1);
          check("hold_data", s_if.m_data, prev_data);
        end
        if (s_if.m_valid && s_if.m_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %0h expected none (t=%0t)", s_if.m_data, $time);
          end else begin
            check("data", s_if.m_data, exp_q.pop_front());
            popped++;
          end
        end
        if (ram_rd_en) begin
          fetch_cnt++;
          if (addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_fetch: got addr %0h expected none (t=%0t)", ram_rd_addr, $time);
          end else begin
            check("addr", ram_rd_addr, addr_q.pop_front());
          end
        end
        prev_stall = s_if.m_valid && !s_if.m_ready;
        prev_data  = s_if.m_data;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    addr_q.push_back(wbin[3:0]);
    wbin = wbin + 5'd1;
    written++;
  endtask

  task automatic publish();
    wr_ptr_gray = wbin ^ (wbin >> 1);
  endtask

  task automatic clear_model();
    wbin        = '0;
    wr_ptr_gray = '0;
    exp_q.delete();
    addr_q.delete();
    written     = 0;
    popped      = 0;
    fetch_cnt   = 0;
  endtask

  task automatic do_reset(input int cycles);
    tick();
    rd_rst      = 1'b1;
    s_if.m_ready = 1'b0;
    clear_model();
    repeat (cycles) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget, input bit rnd_ready);
    int n = 0;
    while ((exp_q.size() != 0 || s_if.m_valid) && n < budget) begin
      tick();
      if (rnd_ready) s_if.m_ready = ($urandom_range(0, 1) == 1);
      @(negedge rd_clk);
      n++;
    end
    tick();
    s_if.m_ready = 1'b1;
    repeat (3) @(negedge rd_clk);
    check({name, "_drained"}, exp_q.size() + 32'(s_if.m_valid), 0);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rd_rst       = 1'b1;
    s_if.m_ready = 1'b0;
    clear_model();

    // Reset: pointer 2 (Gray 00011) offered while reset is held
    push_word(8'h3C);
    push_word(8'hC3);
    publish();
    check("rst_wptr_gray_drive", wr_ptr_gray, 5'b00011);
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_m_data", s_if.m_data, 0);
    check("rst_ram_rd_en", ram_rd_en, 0);
    check("rst_empty", empty, 1);
    check("rst_rd_level", rd_level, 0);
    check("rst_rd_ptr_gray", rd_ptr_gray, 0);
    tick();
    rd_rst = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge rd_clk);
        if (rd_level == 5'd2) seen = 1'b1;
      end
      check("rst_level_reaches_2", seen, 1);
    end
    tick();
    s_if.m_ready = 1'b1;
    wait_drain("rst", 50, 1'b0);
    check("rst_end_ptr", rd_ptr_gray, 5'b00011);
    check("rst_end_empty", empty, 1);

    // Single word
    do_reset(2);
    s_if.m_ready = 1'b1;
    push_word(8'hA5);
    publish();
    begin
      int n = 0;
      while (!s_if.m_valid && n < 10) begin
        @(negedge rd_clk);
        n++;
      end
      check("single_valid_seen", s_if.m_valid, 1);
      check("single_data", s_if.m_data, 8'hA5);
    end
    wait_drain("single", 20, 1'b0);
    check("single_ptr", rd_ptr_gray, 5'b00001);
    check("single_empty", empty, 1);
    check("single_level", rd_level, 0);

    // Burst of 16 with no bubbles
    do_reset(2);
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    publish();
    begin
      int max_lvl = 0;
      int n = 0;
      int acc = 0;
      while (!s_if.m_valid && n < 12) begin
        @(negedge rd_clk);
        if (int'(rd_level) > max_lvl) max_lvl = int'(rd_level);
        n++;
      end
      for (int i = 0; i < 16; i++) begin
        if (s_if.m_valid) acc++;
        @(negedge rd_clk);
      end
      check("burst_max_level", max_lvl, 16);
      check("burst_back_to_back", acc, 16);
    end
    wait_drain("burst", 20, 1'b0);
    check("burst_ptr", rd_ptr_gray, 5'b11000);
    check("burst_level", rd_level, 0);
    check("burst_empty", empty, 1);

    // Backpressure: only two words may be fetched
    do_reset(2);
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    publish();
    repeat (12) @(negedge rd_clk);
    check("bp_fetches", fetch_cnt, 2);
    check("bp_level", rd_level, 6);
    check("bp_valid", s_if.m_valid, 1);
    check("bp_head", s_if.m_data, exp_q[0]);
    check("bp_empty", empty, 0);
    wait_drain("bp", 500, 1'b1);

    // Wrap-around: read pointer 14 -> 18
    do_reset(2);
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 14; i++) push_word(8'($urandom));
    publish();
    wait_drain("wrap_pre", 100, 1'b0);
    check("wrap_ptr14", rd_ptr_gray, 5'b01001);
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    publish();
    wait_drain("wrap", 200, 1'b1);
    check("wrap_ptr18", rd_ptr_gray, 5'b11011);
    check("wrap_empty", empty, 1);
    check("wrap_level", rd_level, 0);

    // Random traffic with random backpressure
    begin
      int target = written + 300;
      int n = 0;
      while (written < target && n < 6000) begin
        tick();
        s_if.m_ready = ($urandom_range(0, 3) != 0);
        if ((written - popped) < 16 && $urandom_range(0, 1) == 1) begin
          push_word(8'($urandom));
          publish();
        end
        n++;
      end
      check("rand_all_written", written, target);
    end
    wait_drain("rand", 2000, 1'b1);
    check("rand_ptr", rd_ptr_gray, wbin ^ (wbin >> 1));
    check("rand_empty", empty, 1);
    check("rand_level", rd_level, 0);

    // Reset mid-burst
    do_reset(2);
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    publish();
    begin
      int n = 0;
      while (popped < 5 && n < 40) begin
        @(negedge rd_clk);
        n++;
      end
      check("mid_streaming", popped >= 5, 1);
    end
    tick();
    rd_rst = 1'b1;
    clear_model();
    @(posedge rd_clk);
    @(negedge rd_clk);
    check("mid_valid", s_if.m_valid, 0);
    check("mid_ptr", rd_ptr_gray, 0);
    check("mid_empty", empty, 1);
    check("mid_level", rd_level, 0);
    check("mid_rd_en", ram_rd_en, 0);
    tick();
    rd_rst = 1'b0;
    s_if.m_ready = 1'b1;
    repeat (8) @(negedge rd_clk);
    check("mid_post_valid", s_if.m_valid, 0);
    check("mid_post_fetch", fetch_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
